ex_muldiv_unit: RTL and testbench

//  EX-stage iterative multiply/divide unit for RV32M; consumes the registered ID/EX operands and funct field.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter_core.sv | 52 +++++
 rtl/ex_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 op codes, the M-extension funct7 tag and the FSM encoding
// shared by ex_muldiv_unit and its iteration core.
package muldiv_pkg;

   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // MUL is treated as unsigned: the low half of the product does not depend on signedness
   function automatic logic rs1_signed(input logic [2:0] f);
      return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
   endfunction

   function automatic logic rs2_signed(input logic [2:0] f);
      return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shared 2*XLEN shift register doing one shift-add multiply step or one
// restoring-divide step per cycle on unsigned magnitudes.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_is_div,
   input  logic [XLEN-1:0]   i_op_a,
   input  logic [XLEN-1:0]   i_op_b,
   output logic [2*XLEN-1:0] o_acc_next
);

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_op;
   logic              r_is_div;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_trial;

   // Multiply: {hi,lo} with multiplier in lo, shift right. Divide: {rem,quot}, shift left.
   always_comb begin
      w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
      w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_op};
      if (!r_is_div)
         o_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
      else if (!w_div_trial[XLEN])
         o_acc_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else
         o_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values; the datapath
   // is reset as well so nothing downstream can ever observe X after reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_acc    <= '0;
         r_op     <= '0;
         r_is_div <= 1'b0;
      end else if (i_load) begin
         r_acc    <= {{XLEN{1'b0}}, i_op_b};
         r_op     <= i_op_a;
         r_is_div <= i_is_div;
      end else if (i_step) begin
         r_acc    <= o_acc_next;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M EX-stage iterative multiply/divide with pipeline stall via busy_o.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam int CW = $clog2(XLEN);

   state_t            r_state, w_state_nx;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic              r_neg, r_rem_neg;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd_o;

   logic              w_sa, w_sb, w_is_div, w_div0, w_ovf, w_fast_mul, w_accept, w_fast, w_last;
   logic [XLEN-1:0]   w_abs1, w_abs2, w_fast_res;
   logic [2*XLEN-1:0] w_fast_prod, w_acc_next;

   // Select the result half and apply the sign of the product, quotient or remainder.
   function automatic logic [XLEN-1:0] sign_fix(input logic [2:0] op, input logic neg,
                                                input logic rem_neg, input logic [2*XLEN-1:0] acc);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo, rem, res;
      prod = neg ? -acc : acc;
      quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op)
         OP_MUL:                      res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             res = quo;
         default:                     res = rem;
      endcase
      return res;
   endfunction

   assign w_sa     = rs1_signed(funct3_i) & rs1_i[XLEN-1];
   assign w_sb     = rs2_signed(funct3_i) & rs2_i[XLEN-1];
   assign w_abs1   = w_sa ? -rs1_i : rs1_i;
   assign w_abs2   = w_sb ? -rs2_i : rs2_i;
   assign w_is_div = funct3_i[2];
   assign w_div0   = w_is_div & (rs2_i == '0);
   assign w_ovf    = ((funct3_i == OP_DIV) || (funct3_i == OP_REM)) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

`ifdef MULDIV_FAST_MUL_EN
   assign w_fast_mul  = ~w_is_div;
   assign w_fast_prod = {{XLEN{1'b0}}, w_abs1} * {{XLEN{1'b0}}, w_abs2};
`else
   assign w_fast_mul  = 1'b0;
   assign w_fast_prod = '0;
`endif

   always_comb begin
      if (w_div0)
         w_fast_res = funct3_i[1] ? rs1_i : '1;
      else if (w_ovf)
         w_fast_res = funct3_i[1] ? '0 : rs1_i;
      else
         w_fast_res = sign_fix(funct3_i, w_sa ^ w_sb, w_sa, w_fast_prod);
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_fast     = 1'b0;
      w_last     = 1'b0;
      case (r_state)
         ST_IDLE: if (valid_i && !flush_i) begin
            w_accept   = 1'b1;
            w_fast     = w_div0 | w_ovf | w_fast_mul;
            w_state_nx = w_fast ? ST_DONE : ST_CALC;
         end
         ST_CALC: if (flush_i) begin
            w_state_nx = ST_IDLE;
         end else if (r_cnt == '0) begin
            w_last     = 1'b1;
            w_state_nx = ST_DONE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_load     (w_accept),
      .i_step     (r_state == ST_CALC),
      .i_is_div   (w_is_div),
      .i_op_a     (w_is_div ? w_abs2 : w_abs1),
      .i_op_b     (w_is_div ? w_abs1 : w_abs2),
      .o_acc_next (w_acc_next)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_result  <= '0;
         r_rd_o    <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_op      <= funct3_i;
            r_rd      <= rd_i;
            r_neg     <= w_sa ^ w_sb;
            r_rem_neg <= w_sa;
            r_cnt     <= CW'(XLEN-1);
            if (w_fast) begin
               r_result <= w_fast_res;
               r_rd_o   <= rd_i;
            end
         end else if (r_state == ST_CALC && !flush_i) begin
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
               r_result <= sign_fix(r_op, r_neg, r_rem_neg, w_acc_next);
               r_rd_o   <= r_rd;
            end
         end
      end
   end

   // Gated by reset so the stall request drops immediately while reset is held.
   assign busy_o   = rst_i & (((r_state == ST_IDLE) & valid_i & ~flush_i) | (r_state == ST_CALC));
   assign done_o   = (r_state == ST_DONE);
   assign result_o = r_result;
   assign rd_o     = r_rd_o;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit; driver pushes expected results from an
// arithmetic reference model, an independent monitor pops on every done_o.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            valid_i = 1'b0;
   logic [2:0]      funct3_i = '0;
   logic [XLEN-1:0] rs1_i = '0;
   logic [XLEN-1:0] rs2_i = '0;
   logic [4:0]      rd_i = '0;
   logic            flush_i = 1'b0;
   logic            busy_o, done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0]      rd_o;

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct3_i(funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          done_cyc;
      int          busy;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   exp_t mon_e;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         OP_MUL:    begin sp = sa * sb; p = sp; return p[31:0];  end
         OP_MULH:   begin sp = sa * sb; p = sp; return p[63:32]; end
         OP_MULHSU: begin sp = sa * longint'(ub); p = sp; return p[63:32]; end
         OP_MULHU:  begin up = ua * ub; p = up; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            sp = sa / sb; p = sp; return p[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sp = sa % sb; p = sp; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bit fast;
      fast = (f[2] && b == 0) ||
             ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) fast = 1'b1;
`endif
      return fast;
   endfunction

   // Called #1 after a posedge with the DUT idle; returns #1 after the edge that ends DONE.
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!done_o && n < 200);
      if (!done_o) check("done_timeout", 64'd0, 64'd1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      exp_t e;
      bit   fast;
      fast       = is_fast(f, a, b);
      valid_i    = 1'b1;
      funct3_i   = f;
      rs1_i      = a;
      rs2_i      = b;
      rd_i       = rd;
      e.res      = ref_result(f, a, b);
      e.rd       = rd;
      e.done_cyc = cyc + 1 + (fast ? 0 : XLEN);
      e.busy     = fast ? 1 : XLEN + 1;
      sb_q.push_back(e);
      wait_done();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: counts stall cycles per op and checks each done_o against the scoreboard head.
   always @(negedge clk_i) begin
      if (!rst_i || flush_i) busy_cnt = 0;
      else if (busy_o) busy_cnt++;
      if (done_o) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", 64'(result_o), 64'(mon_e.res));
            check("rd", 64'(rd_o), 64'(mon_e.rd));
            check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            check("stall_cycles", 64'(busy_cnt), 64'(mon_e.busy));
            check("busy_in_done", 64'(busy_o), 64'd0);
         end
         busy_cnt = 0;
      end
   end

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t dir_q[$] = '{
      '{OP_MUL,    32'd7,          32'hFFFF_FFFD},
      '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF},
      '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF},
      '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2},
      '{OP_DIV,    32'hFFFF_FFF9,  32'd2},
      '{OP_REM,    32'hFFFF_FFF9,  32'd2},
      '{OP_DIVU,   32'd100,        32'd7},
      '{OP_REMU,   32'd100,        32'd7},
      '{OP_DIV,    32'd5,          32'd0},
      '{OP_REM,    32'd5,          32'd0},
      '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF},
      '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF},
      '{OP_DIVU,   32'd5,          32'd0},
      '{OP_REMU,   32'd5,          32'd0},
      '{OP_DIV,    32'h8000_0000,  32'd1},
      '{OP_MULH,   32'h8000_0000,  32'h8000_0000},
      '{OP_DIV,    32'd1000,       32'hFFFF_FFF9},
      '{OP_DIV,    32'd1000,       32'd3}
   };

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_result", 64'(result_o), 64'd0);
      check("reset_rd", 64'(rd_o), 64'd0);
      check("reset_done", 64'(done_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Directed cases; the last two DIVs run back-to-back with valid_i held.
      for (int i = 0; i < dir_q.size(); i++)
         issue(dir_q[i].f, dir_q[i].a, dir_q[i].b, 5'(i + 1));

      // Flush a DIVU mid-calculation: no done_o may follow.
      valid_i = 1'b1; funct3_i = OP_DIVU; rs1_i = 32'd1234; rs2_i = 32'd7; rd_i = 5'd20;
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_busy", 64'(busy_o), 64'd0);
      check("flush_done", 64'(done_o), 64'd0);
      repeat (40) @(posedge clk_i);
      #1;
      check("flush_sb_empty", 64'(sb_q.size()), 64'd0);

      // Known nonzero result, then reset in the middle of a DIVU.
      issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
      valid_i = 1'b1; funct3_i = OP_DIVU; rs1_i = 32'd999; rs2_i = 32'd4; rd_i = 5'd21;
      repeat (5) @(posedge clk_i);
      #1;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      #1;
      check("midop_reset_result", 64'(result_o), 64'd0);
      check("midop_reset_rd", 64'(rd_o), 64'd0);
      check("midop_reset_done", 64'(done_o), 64'd0);
      check("midop_reset_busy", 64'(busy_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      repeat (40) @(posedge clk_i);
      #1;
      check("reset_sb_empty", 64'(sb_q.size()), 64'd0);
      check("reset_idle_busy", 64'(busy_o), 64'd0);

      // Randomised ops with occasional idle gaps.
      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(1, 31)));
         if ($urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
         end
      end
      valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      check("final_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
